// File: rtl/key_event_pkg.sv
// key_event_pkg: state encoding and width helper shared by the key event block.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package key_event_pkg;

    // Per-key hold state: waiting for a press, held short, held past the long threshold
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } key_state_t;

    // Bits needed to hold values 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_event_fsm.sv
// key_event_fsm: one key's 2-flop synchroniser, press/hold FSM, hold and repeat counters.
// Latency: level change before edge N -> pulse registered at edge N+2 (visible after it).
// Backpressure: none; outputs are single-cycle pulses. Repeat logic only with KEY_EVENT_REPEAT_EN.
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int LONG_TICKS   = 1000
`ifdef KEY_EVENT_REPEAT_EN
    ,
    parameter int REPEAT_TICKS = 200
`endif
) (
    input  logic Sys_CLK,
    input  logic Sys_RST_N,
    input  logic tick,
    input  logic key_level,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic RELEASED_LVL = ACTIVE_LOW;
    localparam int   HOLD_W       = cnt_width(LONG_TICKS);
    // Compare against LONG_TICKS-1 on the tick so the transition lands in the cycle the count becomes LONG_TICKS
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

    logic [1:0]        sync_q;
    logic              pressed;
    key_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;

`ifdef KEY_EVENT_REPEAT_EN
    localparam int REP_W = cnt_width(REPEAT_TICKS);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
    logic [REP_W-1:0] rep_cnt;
`else
    assign repeat_pulse = 1'b0;
`endif

    // Two-stage resynchroniser; resets to the released level so no phantom press after reset
    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            sync_q <= {2{RELEASED_LVL}};
        end else begin
            sync_q <= {sync_q[0], key_level};
        end
    end

    assign pressed   = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];
    assign key_state = pressed;

    // Hold FSM with registered pulses; release always takes priority over a tick
    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            rep_cnt       <= '0;
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                    end else if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state      <= LONG;
                            hold_cnt   <= HOLD_MAX;
                            long_pulse <= 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
                            rep_cnt    <= '0;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                LONG: begin
                    // Hold counter stays saturated at LONG_TICKS while here
                    if (!pressed) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
                        rep_cnt       <= '0;
`endif
                    end
`ifdef KEY_EVENT_REPEAT_EN
                    else if (tick) begin
                        if (rep_cnt == REP_LAST) begin
                            rep_cnt      <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event.sv
// key_event: turns debounced key levels into press/release/long/repeat pulses on Sys_CLK.
// Latency: 3 Sys_CLK edges from a stable level change to the press/release pulse.
// Backpressure: none; pulses are fire-and-forget. Auto-repeat built only with KEY_EVENT_REPEAT_EN.
module key_event
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS     = 2,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int TICK_DIV     = 50000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic                Sys_CLK,
    input  logic                Sys_RST_N,
    input  logic [NUM_KEYS-1:0] Key_Level,
    output logic [NUM_KEYS-1:0] Key_State,
    output logic [NUM_KEYS-1:0] Press_Pulse,
    output logic [NUM_KEYS-1:0] Release_Pulse,
    output logic [NUM_KEYS-1:0] Long_Pulse,
    output logic [NUM_KEYS-1:0] Repeat_Pulse
);

    localparam int TICK_W = cnt_width(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    if (TICK_DIV < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("key_event: TICK_DIV must be >= 2, LONG_TICKS and REPEAT_TICKS >= 1");
    end

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running hold-time prescaler shared by all keys
    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_event_fsm #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .LONG_TICKS   (LONG_TICKS)
`ifdef KEY_EVENT_REPEAT_EN
            ,
            .REPEAT_TICKS (REPEAT_TICKS)
`endif
        ) u_fsm (
            .Sys_CLK       (Sys_CLK),
            .Sys_RST_N     (Sys_RST_N),
            .tick          (tick),
            .key_level     (Key_Level[i]),
            .key_state     (Key_State[i]),
            .press_pulse   (Press_Pulse[i]),
            .release_pulse (Release_Pulse[i]),
            .long_pulse    (Long_Pulse[i]),
            .repeat_pulse  (Repeat_Pulse[i])
        );
    end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed checks of key_event with TICK_DIV=10, LONG_TICKS=4, REPEAT_TICKS=3.
// Latency: expectations count edges k from the negedge where Key_Level is driven (k=0).
// Backpressure: n/a. Repeat expectations follow KEY_EVENT_REPEAT_EN.
module tb_key_event;

`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       Sys_CLK;
    logic       Sys_RST_N;
    logic [1:0] Key_Level;
    logic [1:0] Key_State;
    logic [1:0] Press_Pulse;
    logic [1:0] Release_Pulse;
    logic [1:0] Long_Pulse;
    logic [1:0] Repeat_Pulse;

    int n_cmp;
    int n_bad;
    int ecnt;
    logic [9:0] act_v;
    logic [9:0] exp_v;

    key_event #(
        .NUM_KEYS     (2),
        .ACTIVE_LOW   (1'b1),
        .TICK_DIV     (10),
        .LONG_TICKS   (4),
        .REPEAT_TICKS (3)
    ) dut (
        .Sys_CLK       (Sys_CLK),
        .Sys_RST_N     (Sys_RST_N),
        .Key_Level     (Key_Level),
        .Key_State     (Key_State),
        .Press_Pulse   (Press_Pulse),
        .Release_Pulse (Release_Pulse),
        .Long_Pulse    (Long_Pulse),
        .Repeat_Pulse  (Repeat_Pulse)
    );

    initial Sys_CLK = 1'b0;
    always #5 Sys_CLK = ~Sys_CLK;

    // Vector layout: {Key_State, Press, Release, Long, Repeat}, key 1 in the upper bit of each pair
    task automatic cyc();
        @(posedge Sys_CLK);
        ecnt++;
        @(negedge Sys_CLK);
        act_v = {Key_State, Press_Pulse, Release_Pulse, Long_Pulse, Repeat_Pulse};
    endtask

    // Ticks are seen by the FSMs on edges whose count since reset is a multiple of 10
    task automatic align();
        while (ecnt % 10 != 0) cyc();
    endtask

    task automatic test_reset();
        Sys_RST_N = 1'b0;
        Key_Level = 2'b11;
        repeat (3) @(negedge Sys_CLK);
        act_v = {Key_State, Press_Pulse, Release_Pulse, Long_Pulse, Repeat_Pulse};
        n_cmp++;
        if (act_v !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_released got=%b exp=%b", act_v, 10'b0);
        end
        Key_Level = 2'b00;
        repeat (3) @(negedge Sys_CLK);
        act_v = {Key_State, Press_Pulse, Release_Pulse, Long_Pulse, Repeat_Pulse};
        n_cmp++;
        if (act_v !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_pressed_in_reset got=%b exp=%b", act_v, 10'b0);
        end
        Key_Level = 2'b11;
        @(negedge Sys_CLK);
        Sys_RST_N = 1'b1;
        ecnt = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            n_cmp++;
            if (act_v !== 10'b0) begin
                n_bad++;
                $display("FAIL reset_idle k=%0d got=%b exp=%b", k, act_v, 10'b0);
            end
        end
    endtask

    task automatic test_press_release();
        align();
        Key_Level[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            exp_v = {1'b0, (k >= 2 && k <= 21), 1'b0, (k == 3), 1'b0, (k == 23), 4'b0};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL press_release k=%0d got=%b exp=%b", k, act_v, exp_v);
            end
            if (k == 20) Key_Level[0] = 1'b1;
        end
    endtask

    task automatic test_long();
        align();
        Key_Level[1] = 1'b0;
        for (int k = 1; k <= 106; k++) begin
            cyc();
            exp_v = {(k >= 2 && k <= 101), 1'b0, (k == 3), 1'b0, (k == 103), 1'b0,
                     (k == 40), 1'b0, REP_EN && (k == 70 || k == 100), 1'b0};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL long_key1 k=%0d got=%b exp=%b", k, act_v, exp_v);
            end
            if (k == 100) Key_Level[1] = 1'b1;
        end
    endtask

    task automatic test_repeat();
        align();
        Key_Level[0] = 1'b0;
        for (int k = 1; k <= 156; k++) begin
            cyc();
            exp_v = {1'b0, (k >= 2 && k <= 151), 1'b0, (k == 3), 1'b0, (k == 153), 1'b0,
                     (k == 40), 1'b0, REP_EN && (k == 70 || k == 100 || k == 130)};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL repeat_key0 k=%0d got=%b exp=%b", k, act_v, exp_v);
            end
            if (k == 150) Key_Level[0] = 1'b1;
        end
    endtask

    // Release is seen by the FSM on the same edge as the 4th tick (k=40)
    task automatic test_release_on_tick();
        align();
        Key_Level[0] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            exp_v = {1'b0, (k >= 2 && k <= 38), 1'b0, (k == 3), 1'b0, (k == 40), 4'b0};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL release_on_tick k=%0d got=%b exp=%b", k, act_v, exp_v);
            end
            if (k == 37) Key_Level[0] = 1'b1;
        end
    endtask

    task automatic test_both_keys();
        logic ks;
        align();
        Key_Level = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            ks = (k >= 2 && k <= 6);
            exp_v = {ks, ks, (k == 3), (k == 3), (k == 8), (k == 8), 4'b0};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL both_keys k=%0d got=%b exp=%b", k, act_v, exp_v);
            end
            if (k == 5) Key_Level = 2'b11;
        end
    endtask

    task automatic test_reset_mid_hold();
        align();
        Key_Level[0] = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            cyc();
            exp_v = {1'b0, (k >= 2), 1'b0, (k == 3), 2'b0, 1'b0, (k == 40), 2'b0};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL pre_reset_hold k=%0d got=%b exp=%b", k, act_v, exp_v);
            end
        end
        #2;
        Sys_RST_N = 1'b0;
        #1;
        act_v = {Key_State, Press_Pulse, Release_Pulse, Long_Pulse, Repeat_Pulse};
        n_cmp++;
        if (act_v !== 10'b0) begin
            n_bad++;
            $display("FAIL async_reset got=%b exp=%b", act_v, 10'b0);
        end
        repeat (2) @(negedge Sys_CLK);
        Sys_RST_N = 1'b1;
        ecnt = 0;
        for (int k = 1; k <= 55; k++) begin
            cyc();
            exp_v = {1'b0, (k >= 2 && k <= 51), 1'b0, (k == 3), 1'b0, (k == 53), 1'b0,
                     (k == 40), 2'b0};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL post_reset_hold k=%0d got=%b exp=%b", k, act_v, exp_v);
            end
            if (k == 50) Key_Level[0] = 1'b1;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        ecnt      = 0;
        Sys_RST_N = 1'b0;
        Key_Level = 2'b11;
        test_reset();
        test_press_release();
        test_long();
        test_repeat();
        test_release_on_tick();
        test_both_keys();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
